// File: rtl/idct_seq_pkg.sv
// Shared definitions for the IDCT multiplier sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Holds the wrapper state codes, the phase lengths and the product tag type
// that travels alongside each issued MAC.
package idct_seq_pkg;

  // Codes presented on the wrapper state port.
  localparam logic [2:0] S_IDLE  = 3'b000;
  localparam logic [2:0] S_LOAD  = 3'b001;
  localparam logic [2:0] S_ROW   = 3'b010;
  localparam logic [2:0] S_COL   = 3'b011;
  localparam logic [2:0] S_FLUSH = 3'b100;

  // Last count0 value of the load phase and of each MAC pass.
  localparam int LOAD_LAST = 63;
  localparam int PASS_LAST = 511;
  // Idle cycles after a pass so the last products leave the wrapper pipe.
  localparam int DRAIN_CYC = 2;

  // Travels with each issued operand pair until its product appears on P.
  typedef struct packed {
    logic       valid;
    logic [2:0] k;     // term index within the 8-term dot product
    logic [5:0] u;     // output index {row, col}
    logic       pass;  // 0 = row pass, 1 = column pass
  } tag_t;

endpackage

// File: rtl/idct_mac_accum.sv
// Tag delay line plus 8-term accumulator for the IDCT sequencer.
// Latency: tag aligned with P after PROD_LAT cycles; acc_valid one cycle after the k==7 product.
// Backpressure: none; consumes one product per cycle whenever the delayed tag is valid.
// Ports: clk/rst, tag_in (issue-side tag), p_in (wrapper product),
//        acc_out/acc_idx/acc_pass/acc_valid (completed output strobe).
module idct_mac_accum
  import idct_seq_pkg::*;
#(
  parameter int PROD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  tag_t        tag_in,
  input  logic [31:0] p_in,
  output logic [31:0] acc_out,
  output logic [5:0]  acc_idx,
  output logic        acc_pass,
  output logic        acc_valid
);

  tag_t        pipe [PROD_LAT];
  tag_t        tag_at_p;
  logic [31:0] acc;
  logic [31:0] sum;

  // Tag that belongs to the product currently on p_in.
  assign tag_at_p = pipe[PROD_LAT-1];
  // Wraps modulo 2^32 by construction.
  assign sum      = acc + p_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PROD_LAT; i++) pipe[i] <= '0;
      acc       <= '0;
      acc_out   <= '0;
      acc_idx   <= '0;
      acc_pass  <= 1'b0;
      acc_valid <= 1'b0;
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < PROD_LAT; i++) pipe[i] <= pipe[i-1];
      acc_valid <= 1'b0;
      if (tag_at_p.valid) begin
        // First term restarts the sum so no explicit clear is needed between outputs.
        acc <= (tag_at_p.k == 3'd0) ? p_in : sum;
        if (tag_at_p.k == 3'd7) begin
          acc_out   <= sum;
          acc_idx   <= tag_at_p.u;
          acc_pass  <= tag_at_p.pass;
          acc_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/idct_mul_sequencer.sv
// Sequences one 8x8 IDCT block (load, row pass, column pass) through the multiplier wrapper.
// Latency: 1093 cycles from accepted start to done; outputs stream PROD_LAT+1 cycles after issue.
// Backpressure: none; start is ignored while busy, downstream must accept every acc_valid strobe.
// Ports: clk/rstP; start, apx_en; data_in/coef_in (memory reads at data_addr/coef_addr);
//        P_in (wrapper product); state/count0/racc/rapx/A_out/B_out (wrapper controls);
//        acc_out/acc_idx/acc_pass/acc_valid (IDCT outputs); busy, done.
module idct_mul_sequencer
  import idct_seq_pkg::*;
#(
  parameter int OP_BITWIDTH        = 16,
  parameter int DATA_PATH_BITWIDTH = 24,
  parameter int PROD_LAT           = 2
) (
  input  logic                          clk,
  input  logic                          rstP,
  input  logic                          start,
  input  logic                          apx_en,
  input  logic [DATA_PATH_BITWIDTH-1:0] data_in,
  input  logic [DATA_PATH_BITWIDTH-1:0] coef_in,
  input  logic [31:0]                   P_in,
  output logic [2:0]                    state,
  output logic [8:0]                    count0,
  output logic                          racc,
  output logic                          rapx,
  output logic [DATA_PATH_BITWIDTH-1:0] A_out,
  output logic [DATA_PATH_BITWIDTH-1:0] B_out,
  output logic [5:0]                    data_addr,
  output logic [5:0]                    coef_addr,
  output logic [31:0]                   acc_out,
  output logic [5:0]                    acc_idx,
  output logic                          acc_pass,
  output logic                          acc_valid,
  output logic                          busy,
  output logic                          done
);

  // The accurate MSB field handed to the wrapper cannot exceed the operand width.
  if (OP_BITWIDTH > DATA_PATH_BITWIDTH) begin : g_bad_width
    $error("OP_BITWIDTH must not exceed DATA_PATH_BITWIDTH");
  end

  // DRAIN is a separate internal state but shows the ROW code on the wrapper port.
  typedef enum logic [2:0] {
    F_IDLE, F_LOAD, F_ROW, F_DRAIN, F_COL, F_FLUSH, F_DONE
  } fsm_t;

  fsm_t       cur, nxt;
  logic [8:0] cnt, cnt_nxt;
  logic       aux, aux_nxt;  // counts drain and flush cycles
  logic       apx_lat;
  logic       issue;
  logic [5:0] u;
  logic [2:0] k, r, c;
  tag_t       tag_in;

  always_ff @(posedge clk or posedge rstP) begin
    if (rstP) begin
      cur     <= F_IDLE;
      cnt     <= '0;
      aux     <= 1'b0;
      apx_lat <= 1'b0;
    end else begin
      cur <= nxt;
      cnt <= cnt_nxt;
      aux <= aux_nxt;
      if (cur == F_IDLE && start) apx_lat <= apx_en;
    end
  end

  always_comb begin
    nxt     = cur;
    cnt_nxt = cnt;
    aux_nxt = aux;
    case (cur)
      F_IDLE: begin
        cnt_nxt = '0;
        if (start) nxt = F_LOAD;
      end
      F_LOAD: begin
        if (cnt == 9'(LOAD_LAST)) begin
          nxt     = F_ROW;
          cnt_nxt = '0;
        end else cnt_nxt = cnt + 9'd1;
      end
      F_ROW: begin
        // count0 stays at its last value through the drain.
        if (cnt == 9'(PASS_LAST)) begin
          nxt     = F_DRAIN;
          aux_nxt = 1'b0;
        end else cnt_nxt = cnt + 9'd1;
      end
      F_DRAIN: begin
        if (aux == 1'(DRAIN_CYC - 1)) begin
          nxt     = F_COL;
          cnt_nxt = '0;
        end else aux_nxt = aux + 1'b1;
      end
      F_COL: begin
        if (cnt == 9'(PASS_LAST)) begin
          nxt     = F_FLUSH;
          cnt_nxt = '0;
          aux_nxt = 1'b0;
        end else cnt_nxt = cnt + 9'd1;
      end
      F_FLUSH: begin
        if (aux == 1'(DRAIN_CYC - 1)) nxt = F_DONE;
        else aux_nxt = aux + 1'b1;
      end
      F_DONE:  nxt = F_IDLE;
      default: nxt = F_IDLE;
    endcase
  end

  always_comb begin
    state = S_IDLE;
    case (cur)
      F_LOAD:           state = S_LOAD;
      F_ROW, F_DRAIN:   state = S_ROW;
      F_COL:            state = S_COL;
      F_FLUSH:          state = S_FLUSH;
      default:          state = S_IDLE;
    endcase
  end

  assign count0 = cnt;
  assign busy   = (cur != F_IDLE);
  assign done   = (cur == F_DONE);
  assign racc   = (cur == F_IDLE);
  assign rapx   = busy & ~apx_lat;

  // count0 = {u, k}, u = {r, c}
  assign u     = cnt[8:3];
  assign k     = cnt[2:0];
  assign r     = u[5:3];
  assign c     = u[2:0];
  assign issue = (cur == F_ROW) || (cur == F_COL);

  // Row pass walks data rows against coefficient columns; the column pass
  // walks data columns against coefficient rows (transpose on read).
  always_comb begin
    data_addr = '0;
    coef_addr = '0;
    if (cur == F_ROW) begin
      data_addr = {r, k};
      coef_addr = {k, c};
    end else if (cur == F_COL) begin
      data_addr = {k, c};
      coef_addr = {k, r};
    end
  end

  assign A_out = issue ? data_in : '0;
  assign B_out = issue ? coef_in : '0;

  always_comb begin
    tag_in       = '0;
    tag_in.valid = issue;
    tag_in.k     = k;
    tag_in.u     = u;
    tag_in.pass  = (cur == F_COL);
  end

  idct_mac_accum #(
    .PROD_LAT (PROD_LAT)
  ) u_mac_accum (
    .clk       (clk),
    .rst       (rstP),
    .tag_in    (tag_in),
    .p_in      (P_in),
    .acc_out   (acc_out),
    .acc_idx   (acc_idx),
    .acc_pass  (acc_pass),
    .acc_valid (acc_valid)
  );

endmodule

// File: tb/tb_idct_mul_sequencer.sv
module tb_idct_mul_sequencer;

  logic        clk = 1'b0;
  logic        rstP = 1'b1;
  logic        start = 1'b0;
  logic        apx_en = 1'b0;
  logic [23:0] data_in, coef_in, A_out, B_out;
  logic [31:0] P_in, acc_out;
  logic [2:0]  state;
  logic [8:0]  count0;
  logic        racc, rapx, acc_pass, acc_valid, busy, done;
  logic [5:0]  data_addr, coef_addr, acc_idx;

  logic [23:0] data_mem [64];
  logic [23:0] coef_mem [64];
  logic        force_p = 1'b0;
  logic [47:0] full_prod;
  logic [31:0] m1 = '0;
  logic [31:0] p_reg = '0;

  int n_checks = 0;
  int n_fail   = 0;

  // results of the most recent run_block
  int          n_load, n_row, n_col, n_flush, drain511;
  int          done_cnt, done_cyc, last_strobe_cyc;
  int          bad_racc, bad_rapx, bad_busy;
  logic [2:0]  post_state;
  logic        post_busy;
  logic [31:0] sv_q [$];
  logic [5:0]  si_q [$];
  logic        sp_q [$];

  always #5 clk = ~clk;

  idct_mul_sequencer dut (
    .clk       (clk),
    .rstP      (rstP),
    .start     (start),
    .apx_en    (apx_en),
    .data_in   (data_in),
    .coef_in   (coef_in),
    .P_in      (P_in),
    .state     (state),
    .count0    (count0),
    .racc      (racc),
    .rapx      (rapx),
    .A_out     (A_out),
    .B_out     (B_out),
    .data_addr (data_addr),
    .coef_addr (coef_addr),
    .acc_out   (acc_out),
    .acc_idx   (acc_idx),
    .acc_pass  (acc_pass),
    .acc_valid (acc_valid),
    .busy      (busy),
    .done      (done)
  );

  // Block memory and a 2-cycle wrapper model: operand register then product register.
  assign data_in   = data_mem[data_addr];
  assign coef_in   = coef_mem[coef_addr];
  assign full_prod = A_out * B_out;
  always @(posedge clk) begin
    m1    <= full_prod[31:0];
    p_reg <= m1;
  end
  assign P_in = force_p ? 32'h7FFF_FFFF : p_reg;

  // Reference: row pass Y[r][c] = sum_k X[r][k]*C[k][c];
  // column pass Z[r][c] = sum_k X[k][c]*C[k][r]; all modulo 2^32.
  function automatic logic [31:0] ref_out(input bit pass, input int u);
    int          r = u / 8;
    int          c = u % 8;
    logic [31:0] s = '0;
    logic [47:0] pr;
    for (int k = 0; k < 8; k++) begin
      if (force_p)   pr = 48'h7FFF_FFFF;
      else if (!pass) pr = data_mem[r*8+k] * coef_mem[k*8+c];
      else           pr = data_mem[k*8+c] * coef_mem[k*8+r];
      s += pr[31:0];
    end
    return s;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 64; i++) begin
      data_mem[i] = 24'($urandom);
      coef_mem[i] = 24'($urandom);
    end
  endtask

  // Runs one block from a start pulse to one cycle past done, sampling on negedges.
  task automatic run_block(input bit apx, input int poke_cyc, input bit poke_done);
    n_load = 0; n_row = 0; n_col = 0; n_flush = 0; drain511 = 0;
    done_cnt = 0; done_cyc = -1; last_strobe_cyc = -1;
    bad_racc = 0; bad_rapx = 0; bad_busy = 0;
    post_state = 3'b111; post_busy = 1'b1;
    sv_q.delete(); si_q.delete(); sp_q.delete();
    apx_en = apx;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 1; cyc <= 1200; cyc++) begin
      if (done_cnt > 0 && cyc == done_cyc + 1) begin
        post_state = state;
        post_busy  = busy;
        break;
      end
      case (state)
        3'b001: n_load++;
        3'b010: begin n_row++; if (count0 == 9'd511) drain511++; end
        3'b011: n_col++;
        3'b100: n_flush++;
        default: ;
      endcase
      if (racc !== 1'b0) bad_racc++;
      if (rapx !== ~apx) bad_rapx++;
      if (busy !== 1'b1) bad_busy++;
      if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
      if (acc_valid === 1'b1) begin
        sv_q.push_back(acc_out);
        si_q.push_back(acc_idx);
        sp_q.push_back(acc_pass);
        last_strobe_cyc = cyc;
      end
      start = (cyc == poke_cyc) || (poke_done && done === 1'b1);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    int bad = 0;
    rstP = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (state !== 3'b000) begin n_fail++; $display("FAIL rst_state got %b want 000", state); end
    n_checks++; if (racc !== 1'b1) begin n_fail++; $display("FAIL rst_racc got %b want 1", racc); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
    n_checks++; if (acc_valid !== 1'b0) begin n_fail++; $display("FAIL rst_acc_valid got %b want 0", acc_valid); end
    n_checks++; if (count0 !== 9'd0 || rapx !== 1'b0 || done !== 1'b0 || acc_out !== 32'd0) begin
      n_fail++; $display("FAIL rst_misc got count0=%0d rapx=%b done=%b acc_out=%h want 0/0/0/0", count0, rapx, done, acc_out);
    end
    rstP = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (state !== 3'b000 || racc !== 1'b1 || busy !== 1'b0 || acc_valid !== 1'b0 || done !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL idle_hold got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_sequencing();
    fill_random();
    run_block(1'b0, 300, 1'b0);  // start re-asserted mid ROW must be ignored
    n_checks++; if (n_load != 64) begin n_fail++; $display("FAIL seq_load got %0d want 64", n_load); end
    n_checks++; if (n_row != 514) begin n_fail++; $display("FAIL seq_row got %0d want 514", n_row); end
    n_checks++; if (n_col != 512) begin n_fail++; $display("FAIL seq_col got %0d want 512", n_col); end
    n_checks++; if (n_flush != 2) begin n_fail++; $display("FAIL seq_flush got %0d want 2", n_flush); end
    n_checks++; if (done_cyc != 1093 || done_cnt != 1) begin
      n_fail++; $display("FAIL seq_done got cyc=%0d cnt=%0d want cyc=1093 cnt=1", done_cyc, done_cnt);
    end
    n_checks++; if (drain511 != 3) begin n_fail++; $display("FAIL seq_drain_count0 got %0d want 3", drain511); end
    n_checks++; if (bad_racc + bad_rapx + bad_busy != 0) begin
      n_fail++; $display("FAIL seq_ctrl got racc_bad=%0d rapx_bad=%0d busy_bad=%0d want 0", bad_racc, bad_rapx, bad_busy);
    end
    n_checks++; if (sv_q.size() != 128) begin n_fail++; $display("FAIL seq_strobes got %0d want 128", sv_q.size()); end
    n_checks++; if (last_strobe_cyc > done_cyc || last_strobe_cyc < 0) begin
      n_fail++; $display("FAIL seq_last_strobe got cyc=%0d want <= %0d", last_strobe_cyc, done_cyc);
    end
    for (int i = 0; i < sv_q.size(); i++) begin
      n_checks++;
      if (sv_q[i] !== ref_out(i >= 64, i % 64) || si_q[i] !== 6'(i % 64) || sp_q[i] !== (i >= 64)) begin
        n_fail++;
        $display("FAIL seq_out[%0d] got val=%h idx=%0d pass=%b want val=%h idx=%0d pass=%0d",
                 i, sv_q[i], si_q[i], sp_q[i], ref_out(i >= 64, i % 64), i % 64, i >= 64);
      end
    end
  endtask

  task automatic test_identity();
    for (int i = 0; i < 64; i++) begin data_mem[i] = 24'd1; coef_mem[i] = 24'd1; end
    run_block(1'b0, 0, 1'b0);
    n_checks++; if (sv_q.size() != 128) begin n_fail++; $display("FAIL ident_strobes got %0d want 128", sv_q.size()); end
    for (int i = 0; i < sv_q.size(); i++) begin
      n_checks++;
      if (sv_q[i] !== 32'd8 || si_q[i] !== 6'(i % 64) || sp_q[i] !== (i >= 64)) begin
        n_fail++;
        $display("FAIL ident_out[%0d] got val=%0d idx=%0d pass=%b want val=8 idx=%0d pass=%0d",
                 i, sv_q[i], si_q[i], sp_q[i], i % 64, i >= 64);
      end
    end
  endtask

  task automatic test_addressing();
    // X[r][k] = 8r+k and C = identity: both passes reproduce X, so output u equals u.
    for (int i = 0; i < 64; i++) begin
      data_mem[i] = 24'(i);
      coef_mem[i] = ((i / 8) == (i % 8)) ? 24'd1 : 24'd0;
    end
    run_block(1'b0, 0, 1'b0);
    n_checks++; if (sv_q.size() != 128) begin n_fail++; $display("FAIL addr_strobes got %0d want 128", sv_q.size()); end
    for (int i = 0; i < sv_q.size(); i++) begin
      n_checks++;
      if (sv_q[i] !== 32'(i % 64) || si_q[i] !== 6'(i % 64)) begin
        n_fail++;
        $display("FAIL addr_out[%0d] got val=%0d idx=%0d want val=%0d idx=%0d", i, sv_q[i], si_q[i], i % 64, i % 64);
      end
    end
  endtask

  task automatic test_overflow();
    fill_random();
    force_p = 1'b1;
    run_block(1'b0, 0, 1'b1);  // also holds start high on the DONE cycle
    force_p = 1'b0;
    n_checks++; if (sv_q.size() != 128) begin n_fail++; $display("FAIL ovf_strobes got %0d want 128", sv_q.size()); end
    for (int i = 0; i < sv_q.size(); i++) begin
      n_checks++;
      if (sv_q[i] !== 32'hFFFF_FFF8) begin
        n_fail++; $display("FAIL ovf_out[%0d] got %h want fffffff8", i, sv_q[i]);
      end
    end
    n_checks++; if (post_state !== 3'b000 || post_busy !== 1'b0) begin
      n_fail++; $display("FAIL start_on_done got state=%b busy=%b want 000/0", post_state, post_busy);
    end
    @(negedge clk);
    n_checks++; if (state !== 3'b000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL start_on_done_late got state=%b busy=%b want 000/0", state, busy);
    end
  endtask

  task automatic test_abort_then_restart();
    bit found = 1'b0;
    int bad = 0;
    fill_random();
    apx_en = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      if (state === 3'b011 && count0 === 9'd200) begin found = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL abort_reach got not-found want COL count0=200"); end
    n_checks++; if (rapx !== 1'b0) begin n_fail++; $display("FAIL abort_rapx got %b want 0", rapx); end
    rstP = 1'b1;
    #1;
    n_checks++; if (state !== 3'b000 || busy !== 1'b0 || racc !== 1'b1 || count0 !== 9'd0 || acc_valid !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL abort_reset got state=%b busy=%b racc=%b count0=%0d acc_valid=%b done=%b want 000/0/1/0/0/0",
                         state, busy, racc, count0, acc_valid, done);
    end
    @(negedge clk); rstP = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || acc_valid !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL abort_quiet got %0d bad cycles want 0", bad); end
    fill_random();
    run_block(1'b1, 0, 1'b0);
    n_checks++; if (sv_q.size() != 128 || done_cnt != 1) begin
      n_fail++; $display("FAIL restart_strobes got %0d strobes %0d done want 128/1", sv_q.size(), done_cnt);
    end
    n_checks++; if (bad_rapx != 0) begin n_fail++; $display("FAIL restart_rapx got %0d bad cycles want 0", bad_rapx); end
    for (int i = 0; i < sv_q.size(); i++) begin
      n_checks++;
      if (sv_q[i] !== ref_out(i >= 64, i % 64) || si_q[i] !== 6'(i % 64) || sp_q[i] !== (i >= 64)) begin
        n_fail++;
        $display("FAIL restart_out[%0d] got val=%h idx=%0d pass=%b want val=%h idx=%0d pass=%0d",
                 i, sv_q[i], si_q[i], sp_q[i], ref_out(i >= 64, i % 64), i % 64, i >= 64);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin data_mem[i] = '0; coef_mem[i] = '0; end
    test_reset();
    test_sequencing();
    test_identity();
    test_addressing();
    test_overflow();
    test_abort_then_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
